// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: run-time divisor SCL generator with fall/low-mid/rise/high-mid phase strobes.
// Optional clock stretching in the first high quarter is enabled with macro CLK_STRETCH_EN.
module i2c_scl_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             scl_in_i,
    output logic             scl_o,
    output logic             fall_stb_o,
    output logic             low_mid_stb_o,
    output logic             rise_stb_o,
    output logic             high_mid_stb_o,
    output logic             stretch_o
);

    typedef enum logic [1:0] {
        LOW_A  = 2'd0,
        LOW_B  = 2'd1,
        HIGH_A = 2'd2,
        HIGH_B = 2'd3
    } phase_t;

    phase_t           phase, phase_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] div_q, div_n;
    logic             running, running_n;
    logic             scl_n, fall_n, low_mid_n, rise_n, high_mid_n, stretch_n;
    logic             hold;

`ifdef CLK_STRETCH_EN
    // A slave holding SCL low freezes the first high quarter.
    assign hold = (phase == HIGH_A) && !scl_in_i;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in_i;
    assign hold          = 1'b0;
`endif

    always_comb begin
        phase_n    = phase;
        cnt_n      = cnt;
        div_n      = div_q;
        running_n  = running;
        scl_n      = scl_o;
        fall_n     = 1'b0;
        low_mid_n  = 1'b0;
        rise_n     = 1'b0;
        high_mid_n = 1'b0;
        stretch_n  = 1'b0;
        if (!en_i) begin
            running_n = 1'b0;
            phase_n   = LOW_A;
            cnt_n     = '0;
            scl_n     = 1'b1;
        end else if (!running) begin
            running_n = 1'b1;
            phase_n   = LOW_A;
            cnt_n     = '0;
            div_n     = div_i;
            scl_n     = 1'b0;
            fall_n    = 1'b1;
        end else if (hold) begin
            stretch_n = 1'b1;
        end else if (cnt == div_q) begin
            cnt_n = '0;
            unique case (phase)
                LOW_A: begin
                    phase_n   = LOW_B;
                    scl_n     = 1'b0;
                    low_mid_n = 1'b1;
                end
                LOW_B: begin
                    phase_n = HIGH_A;
                    scl_n   = 1'b1;
                    rise_n  = 1'b1;
                end
                HIGH_A: begin
                    phase_n    = HIGH_B;
                    scl_n      = 1'b1;
                    high_mid_n = 1'b1;
                end
                HIGH_B: begin
                    // New divisor only ever takes effect at a period boundary.
                    phase_n = LOW_A;
                    scl_n   = 1'b0;
                    fall_n  = 1'b1;
                    div_n   = div_i;
                end
                default: phase_n = LOW_A;
            endcase
        end else begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            phase          <= LOW_A;
            cnt            <= '0;
            div_q          <= '0;
            running        <= 1'b0;
            scl_o          <= 1'b1;
            fall_stb_o     <= 1'b0;
            low_mid_stb_o  <= 1'b0;
            rise_stb_o     <= 1'b0;
            high_mid_stb_o <= 1'b0;
            stretch_o      <= 1'b0;
        end else begin
            phase          <= phase_n;
            cnt            <= cnt_n;
            div_q          <= div_n;
            running        <= running_n;
            scl_o          <= scl_n;
            fall_stb_o     <= fall_n;
            low_mid_stb_o  <= low_mid_n;
            rise_stb_o     <= rise_n;
            high_mid_stb_o <= high_mid_n;
            stretch_o      <= stretch_n;
        end
    end

endmodule

// File: doc/i2c_scl_gen.md
Name: i2c_scl_gen

Overview:
Programmable-rate I2C SCL generator. It replaces the fixed-DIVIDER clock divider in the i2c subsystem.
- Divides clk_i by a run-time divisor and produces an open-drain-style SCL level.
- Emits four single-cycle phase strobes so the byte/bit FSM can launch SDA at low-mid and sample SDA at high-mid.
- Sits between the i2c master FSM and the SCL pad logic.

Parameters:
CNT_W, 16, width of the quarter-period divisor and internal counter.

Ports:
clk_i  in  1  system clock.
rst_n_i  in  1  synchronous active-low reset.
en_i  in  1  run SCL; low = idle (SCL released high).
div_i  in  CNT_W  quarter-period length minus one, in clk_i cycles.
scl_in_i  in  1  SCL line level, already synchronised by the instantiator (used only with stretching).
scl_o  out  1  SCL level to drive (1 = released/high).
fall_stb_o  out  1  pulse: SCL falls this cycle.
low_mid_stb_o  out  1  pulse: middle of SCL low (SDA change point).
rise_stb_o  out  1  pulse: SCL rises this cycle.
high_mid_stb_o  out  1  pulse: middle of SCL high (SDA sample point).
stretch_o  out  1  high while the quarter counter is frozen by clock stretching.

Behaviour:
- One clock; reset is synchronous and active-low: clk_i, rst_n_i. All outputs are registered.
- Reset values: scl_o=1; all strobes 0; stretch_o=0; counter=0; phase=LOW_A; div_q=0.
- Phases, in cyclic order LOW_A -> LOW_B -> HIGH_A -> HIGH_B -> LOW_A:
  - LOW_A: scl_o=0
  - LOW_B: scl_o=0
  - HIGH_A: scl_o=1
  - HIGH_B: scl_o=1
- Counter: counts 0..div_q, one increment per cycle. On the cycle it equals div_q it wraps to 0 and the phase advances.
- A quarter therefore lasts div_q+1 cycles. The SCL period is 4*(div_q+1) cycles.
- Strobes are asserted in the same cycle the new phase becomes visible on the registered outputs:
  - entering LOW_A: fall_stb_o=1, scl_o 1->0
  - entering LOW_B: low_mid_stb_o=1
  - entering HIGH_A: rise_stb_o=1, scl_o 0->1
  - entering HIGH_B: high_mid_stb_o=1
- At most one strobe is high in any cycle. Each strobe is exactly 1 cycle wide.
- div_i sampling: latched into div_q on the idle->run transition and on every entry to LOW_A. A mid-period change of div_i takes effect at the next period boundary, never mid-quarter.
- Start: the first cycle after en_i is sampled high while idle gives scl_o=0, fall_stb_o=1, phase=LOW_A, counter=0.
- Stop/abort: the cycle after en_i is sampled low, scl_o=1, strobes 0, stretch_o=0, counter=0, phase=LOW_A. This applies in any phase; no period completion.
- div_i=0: every phase lasts 1 cycle, period 4. The pulses fall, low_mid, rise, high_mid occur on consecutive cycles.
- div_i = all-ones: no overflow. The counter is CNT_W bits wide and the compare is exact.
- rst_n_i low overrides en_i and returns to reset values in the next cycle, from any phase.

Optional Feature:
CLK_STRETCH_EN
- Defined:
  - In HIGH_A, the counter increments only on cycles where scl_in_i=1. While scl_in_i=0, the counter holds and stretch_o=1.
  - The HIGH_A quarter therefore counts div_q+1 cycles of observed-high SCL.
  - scl_o stays 1 during stretching; rise_stb_o is not repeated.
  - en_i low still aborts immediately.
- Undefined:
  - scl_in_i is ignored and stretch_o is tied 0.
  - Timing is purely counter-based.

Test Plan:
- Reset/idle: rst_n_i=0 for 3 cycles, en_i=0 -> scl_o=1, all strobes 0, stretch_o=0 for 20 cycles after release.
- Nominal rate: div_i=4, en_i=1 -> scl_o period 20 cycles (10 low, 10 high). Pulse spacing: fall -> low_mid 5, low_mid -> rise 5, rise -> high_mid 5, high_mid -> fall 5. No overlapping strobes.
- Minimum divisor: div_i=0 -> scl_o=0,0,1,1 repeating. Strobes fall, low_mid, rise, high_mid on consecutive cycles.
- Divisor change: div_i 4->9 written mid HIGH_A -> current period remains 20 cycles, next period 40 cycles. The change takes effect exactly at the next fall_stb_o.
- Abort: en_i dropped in LOW_B, counter=2 -> next cycle scl_o=1, no strobes. Re-enable gives fall_stb_o on the first enabled cycle with counter=0.
- Stretch (CLK_STRETCH_EN): div_i=3, scl_in_i held 0 for 7 cycles after rise_stb_o -> stretch_o=1 for those 7 cycles. high_mid_stb_o appears 7 cycles later than without stretching. Without the macro, same stimulus -> no delay, stretch_o=0.
